// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, select
// encodings, FSM state type and the packed control vector.
// Optional feature macro: MC_BNE_EN adds the bne opcode and BRANCHNE state.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_ADDIEXEC,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP
`ifdef MC_BNE_EN
        , S_BRANCHNE
`endif
    } state_t;

    localparam int STATE_W = $bits(state_t);

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // True for every opcode the sequencer knows how to execute.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
`ifdef MC_BNE_EN
        legal = legal || (op == OP_BNE);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the current FSM state to the datapath control
// vector. While reset is high the FETCH vector is produced with the PC/IR
// write strobes suppressed, so no write escapes in the reset cycle.
// Optional feature macro: MC_BNE_EN (BRANCHNE outputs).
module mc_output_decode
    import mips_pkg::*;
(
    input  logic                reset,
    input  logic [STATE_W-1:0]  state_bits,
    input  logic [5:0]          op,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [CTRL_W-1:0]   ctrl_bits
);

    ctrl_t  ctrl;
    state_t state;

    assign ctrl_bits = ctrl;

    // Control vector per state; everything not named for a state stays 0.
    always_comb begin
        ctrl  = '0;
        state = reset ? S_FETCH : state_t'(state_bits);
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = mem_ready & ~reset;
                ctrl.pcen    = mem_ready & ~reset;
            end
            S_DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMMSH;
                if (!op_is_legal(op)) begin
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_B;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.regdst     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.regwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUSRCB_B;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcen       = zero;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BRANCHNE: begin
                ctrl.alusrca    = 1'b1;
                ctrl.alusrcb    = ALUSRCB_B;
                ctrl.aluop      = ALUOP_SUB;
                ctrl.pcsrc      = PCSRC_ALUOUT;
                ctrl.pcen       = ~zero;
                ctrl.instr_done = 1'b1;
            end
`endif
            S_JUMP: begin
                ctrl.pcsrc      = PCSRC_JUMP;
                ctrl.pcen       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic, with the
// per-state control vector produced by mc_output_decode.
// Optional feature macro: MC_BNE_EN (bne opcode via BRANCHNE state).
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t              state_reg;
    state_t              state_next;
    logic [CTRL_W-1:0]   ctrl_bits;
    ctrl_t               ctrl;

    // State register; reset from any state lands in FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: memory states wait for mem_ready, DECODE dispatches on op.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_ADDI:      state_next = S_ADDIEXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = S_BRANCHNE;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ADDIEXEC: state_next = S_ADDIWB;
            default:    state_next = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .reset      (reset),
        .state_bits (state_reg),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ctrl_bits  (ctrl_bits)
    );

    assign ctrl       = ctrl_t'(ctrl_bits);
    assign mem_req    = ctrl.mem_req;
    assign memwrite   = ctrl.memwrite;
    assign iord       = ctrl.iord;
    assign irwrite    = ctrl.irwrite;
    assign pcen       = ctrl.pcen;
    assign pcsrc      = ctrl.pcsrc;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign regwrite   = ctrl.regwrite;
    assign instr_done = ctrl.instr_done;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each instruction is expanded
// into a per-cycle list of expected control words derived from the
// instruction's phases (fetch, decode, execute/memory/writeback), then
// replayed against the DUT. Honours MC_BNE_EN when defined.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb, aluop;
    logic       regdst, memtoreg, regwrite, instr_done, illegal_op;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .pcsrc      (pcsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        logic        rdy;
        logic [5:0]  opc;
        logic        z;
        logic        rst;
    } step_t;

    step_t q[$];
    int    total = 0;
    int    bad   = 0;

    // Control word layout:
    // {mem_req,memwrite,iord,irwrite,pcen,pcsrc,alusrca,alusrcb,aluop,
    //  regdst,memtoreg,regwrite,instr_done,illegal_op}
    function automatic logic [16:0] mk(input logic req, input logic mw,
                                       input logic ad, input logic irw,
                                       input logic pce, input logic [1:0] pcs,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic rd,
                                       input logic m2r, input logic rw,
                                       input logic dn, input logic il);
        return {req, mw, ad, irw, pce, pcs, asa, asb, aop, rd, m2r, rw, dn, il};
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        logic l;
        l = (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
            (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
`ifdef MC_BNE_EN
        l = l || (o == 6'b000101);
`endif
        return l;
    endfunction

    task automatic push(input logic [16:0] v, input logic rdy,
                        input logic [5:0] o, input logic z, input logic rst);
        step_t s;
        s.v = v; s.rdy = rdy; s.opc = o; s.z = z; s.rst = rst;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycles. fw = fetch wait
    // cycles, mw = memory wait cycles for lw/sw.
    task automatic build(input logic [5:0] o, input logic z, input int fw, input int mw);
        logic [5:0] junk;
        logic       r;
        for (int i = 0; i <= fw; i++) begin
            r    = (i == fw);
            junk = 6'($urandom);
            push(mk(1,0,0,r,r,2'b00,0,2'b01,2'b00,0,0,0,0,0), r, junk, z, 0);
        end
        r = is_legal(o);
        push(mk(0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,!r,!r), 1'($urandom), o, z, 0);
        if (r) begin
            case (o)
                6'b100011: begin
                    push(mk(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0), 1'($urandom), o, z, 0);
                    for (int i = 0; i <= mw; i++)
                        push(mk(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,0), (i == mw), o, z, 0);
                    push(mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,1,0), 1'($urandom), o, z, 0);
                end
                6'b101011: begin
                    push(mk(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0), 1'($urandom), o, z, 0);
                    for (int i = 0; i <= mw; i++)
                        push(mk(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,(i == mw),0), (i == mw), o, z, 0);
                end
                6'b000000: begin
                    push(mk(0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,0), 1'($urandom), o, z, 0);
                    push(mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,1,0), 1'($urandom), o, z, 0);
                end
                6'b001000: begin
                    push(mk(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,0), 1'($urandom), o, z, 0);
                    push(mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,1,0), 1'($urandom), o, z, 0);
                end
                6'b000100:
                    push(mk(0,0,0,0,z,2'b01,1,2'b00,2'b01,0,0,0,1,0), 1'($urandom), o, z, 0);
                6'b000101:
                    push(mk(0,0,0,0,!z,2'b01,1,2'b00,2'b01,0,0,0,1,0), 1'($urandom), o, z, 0);
                default:
                    push(mk(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,0,0,1,0), 1'($urandom), o, z, 0);
            endcase
        end
    endtask

    // Reset-cycle expectation: FETCH outputs with PC/IR strobes held low.
    task automatic push_reset();
        push(mk(1,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,0), 1'b1, 6'($urandom), 1'($urandom), 1'b1);
    endtask

    // Replay n queued cycles; done_at = 1-based cycle of first DUT instr_done.
    task automatic run(input int n, output int done_at);
        step_t       s;
        logic [16:0] act;
        done_at = -1;
        for (int k = 0; k < n; k++) begin
            s         = q.pop_front();
            reset     = s.rst;
            mem_ready = s.rdy;
            op        = s.opc;
            zero      = s.z;
            @(negedge clk);
            act = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                   aluop, regdst, memtoreg, regwrite, instr_done, illegal_op};
            total++;
            if (act !== s.v) begin
                bad++;
                $display("FAIL ctrl cycle=%0d op=%b rst=%0b rdy=%0b z=%0b actual=%05h required=%05h",
                         k + 1, s.opc, s.rst, s.rdy, s.z, act, s.v);
            end
            if (act[1] && done_at < 0) done_at = k + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_instr(input string name, input logic [5:0] o, input logic z,
                            input int fw, input int mw, input int exp_len);
        int n, d;
        build(o, z, fw, mw);
        n = q.size();
        chk({name, "_len"}, n, exp_len);
        run(n, d);
        chk({name, "_done_at"}, d, exp_len);
        $display("instr %s op=%b z=%0b fw=%0d mw=%0d cycles=%0d done_at=%0d", name, o, z, fw, mw, n, d);
    endtask

    initial begin
        int d, n, sel, fw, mw;
        logic [5:0] o;
        reset = 1'b1; mem_ready = 1'b0; op = 6'd0; zero = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for two cycles with mem_ready high.
        push_reset();
        push_reset();
        run(2, d);
        $display("reset: two cycles checked");

        // Directed cases with hand-computed cycle counts.
        do_instr("rtype", 6'b000000, 1'b0, 0, 0, 4);
        do_instr("lw_w3", 6'b100011, 1'b0, 0, 3, 8);
        do_instr("beq_z1", 6'b000100, 1'b1, 0, 0, 3);
        do_instr("beq_z0", 6'b000100, 1'b0, 0, 0, 3);
        do_instr("j", 6'b000010, 1'b0, 0, 0, 3);
        do_instr("sw", 6'b101011, 1'b0, 0, 0, 4);
        do_instr("addi", 6'b001000, 1'b1, 0, 0, 4);
        do_instr("illegal", 6'b111111, 1'b0, 0, 0, 2);
`ifdef MC_BNE_EN
        do_instr("bne_z0", 6'b000101, 1'b0, 0, 0, 3);
`else
        do_instr("bne_off", 6'b000101, 1'b0, 0, 0, 2);
`endif

        // Reset during the first MEMWR wait cycle of a sw.
        build(6'b101011, 1'b0, 0, 3);
        run(4, d);
        q.delete();
        push_reset();
        run(1, d);
        $display("reset during sw wait: checked");
        do_instr("j_after_rst", 6'b000010, 1'b0, 0, 0, 3);

        // Randomized instruction stream.
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: o = 6'b000000;
                1: o = 6'b100011;
                2: o = 6'b101011;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                6: o = 6'b000101;
                default: o = 6'($urandom);
            endcase
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            build(o, 1'($urandom), fw, mw);
            n = q.size();
            run(n, d);
            chk("rand_done_at", d, n);
            $display("rand %0d op=%b fw=%0d mw=%0d cycles=%0d", t, o, fw, mw, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
